// File: rtl/key_shift_loader.sv
// Serial key loader: shifts in a 5-bit even-parity frame and commits the
// 4 key bits to registered outputs p1..p4 that feed the locked c432 netlist.
module key_shift_loader #(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          LOCK_ONCE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_start,
  input  logic key_in,
  input  logic key_vld,
  output logic key_rdy,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic key_ok,
  output logic key_err,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StShift, StCheck, StLocked} state_e;

  // Timeout fires on the idle cycle that brings the count up to TIMEOUT.
  localparam logic [15:0] TMax = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [4:0]  sr_q, sr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [3:0]  key_q, key_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        accept;

  assign key_rdy = (state_q == StShift);
  assign busy    = (state_q == StShift) || (state_q == StCheck);
  assign accept  = key_rdy && key_vld;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    key_d   = key_q;
    ok_d    = ok_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          if (LOCK_ONCE && ok_q) begin
            err_d   = 1'b1;
            state_d = StLocked;
          end else begin
            state_d = StShift;
            sr_d    = '0;
            bcnt_d  = '0;
            tcnt_d  = '0;
          end
        end
      end
      StShift: begin
        if (accept) begin
          sr_d   = {sr_q[3:0], key_in};
          bcnt_d = bcnt_q + 3'd1;
          tcnt_d = '0;
          if (bcnt_q == 3'd4) state_d = StCheck;
        end else if (tcnt_q == TMax) begin
          state_d = StIdle;
          err_d   = 1'b1;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        // First accepted bit sits in sr_q[4]; sr_q[0] is the parity bit.
        if (!(^sr_q)) begin
          key_d = sr_q[4:1];
          ok_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      StLocked: begin
        if (load_start) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      key_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      key_q   <= key_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign p1      = key_q[3];
  assign p2      = key_q[2];
  assign p3      = key_q[1];
  assign p4      = key_q[0];
  assign key_ok  = ok_q;
  assign key_err = err_q;

endmodule
